// File: rtl/output_vc_scheduler_pkg.sv
// Shared constants and state encoding for the output-port VC scheduler.
package output_vc_scheduler_pkg;

    localparam int unsigned NUM_VC     = 4;
    localparam int unsigned VC_W       = 2;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MAX_FLITS  = 16;
    localparam int unsigned CNT_W      = 16;
    // Wide enough to hold MAX_FLITS itself, where the counter saturates.
    localparam int unsigned FLIT_CNT_W = $clog2(MAX_FLITS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

endpackage

// File: rtl/output_vc_scheduler_rr_arbiter.sv
// Combinational rotate-priority encoder: first requester after 'last', with wrap-around.
module output_vc_scheduler_rr_arbiter
    import output_vc_scheduler_pkg::*;
(
    input  logic [NUM_VC-1:0] req,
    input  logic [VC_W-1:0]   last,
    output logic [VC_W-1:0]   gnt_idx,
    output logic              any_req
);

    always_comb begin
        gnt_idx = last;
        any_req = 1'b0;
        for (int unsigned k = 1; k <= NUM_VC; k++) begin
            if (!any_req && req[VC_W'((32'(last) + k) % NUM_VC)]) begin
                gnt_idx = VC_W'((32'(last) + k) % NUM_VC);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_vc_scheduler.sv
// Wormhole scheduler: round-robin picks a VC, then the port stays locked to it until its tail.
module output_vc_scheduler
    import output_vc_scheduler_pkg::*;
(
    input  logic                     wr_clk,
    input  logic                     reset,
    input  logic [NUM_VC-1:0]        vc_req,
    input  logic [NUM_VC*DATA_W-1:0] vc_data,
    input  logic [NUM_VC-1:0]        vc_tail,
    input  logic                     buf_rd,
    output logic [NUM_VC-1:0]        vc_ack,
    output logic [DATA_W-1:0]        ors_data_out,
    output logic                     valid_data,
    output logic [VC_W-1:0]          grant_vc,
    output logic                     busy,
    output logic [CNT_W-1:0]         pkt_count,
    output logic                     len_err
);

    state_e                state;
    logic [FLIT_CNT_W-1:0] flit_cnt;
    logic [VC_W-1:0]       gnt_idx;
    logic                  any_req;
    logic                  ack;
    logic [DATA_W-1:0]     cur_data;
    logic                  cur_tail;

    output_vc_scheduler_rr_arbiter u_rr_arbiter (
        .req     (vc_req),
        .last    (grant_vc),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    assign cur_data = vc_data[32'(grant_vc) * DATA_W +: DATA_W];
    assign cur_tail = vc_tail[grant_vc];

    // Pop strobe is gated by reset so no FIFO is drained while the port is held in reset.
    always_comb begin
        vc_ack = '0;
        if (reset && (state == LOCK) && buf_rd) begin
            vc_ack[grant_vc] = vc_req[grant_vc];
        end
    end

    assign ack = |vc_ack;

    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ors_data_out <= '0;
            valid_data   <= 1'b0;
            grant_vc     <= VC_W'(NUM_VC - 1);
            busy         <= 1'b0;
            pkt_count    <= '0;
            len_err      <= 1'b0;
            flit_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_data <= 1'b0;
                    if (any_req) begin
                        grant_vc <= gnt_idx;
                        busy     <= 1'b1;
                        state    <= LOCK;
                    end
                end
                LOCK: begin
                    valid_data <= ack;
                    if (ack) begin
                        ors_data_out <= cur_data;
                        if (cur_tail) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            pkt_count <= pkt_count + CNT_W'(1);
                            flit_cnt  <= '0;
                        end else if (flit_cnt != FLIT_CNT_W'(MAX_FLITS)) begin
                            flit_cnt <= flit_cnt + FLIT_CNT_W'(1);
                            // This non-tail flit is number MAX_FLITS: the packet is overlong.
                            if (flit_cnt == FLIT_CNT_W'(MAX_FLITS - 1)) begin
                                len_err <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_vc_scheduler.sv
// Bench for output_vc_scheduler: directed scenarios plus randomized traffic against a flit-queue model.
module tb_output_vc_scheduler;

    localparam int NV   = 4;
    localparam int DW   = 32;
    localparam int MAXF = 16;

    logic             wr_clk = 1'b0;
    logic             reset  = 1'b0;
    logic [NV-1:0]    vc_req = '0;
    logic [NV*DW-1:0] vc_data = '0;
    logic [NV-1:0]    vc_tail = '0;
    logic             buf_rd = 1'b0;
    logic [NV-1:0]    vc_ack;
    logic [DW-1:0]    ors_data_out;
    logic             valid_data;
    logic [1:0]       grant_vc;
    logic             busy;
    logic [15:0]      pkt_count;
    logic             len_err;

    output_vc_scheduler dut (
        .wr_clk       (wr_clk),
        .reset        (reset),
        .vc_req       (vc_req),
        .vc_data      (vc_data),
        .vc_tail      (vc_tail),
        .buf_rd       (buf_rd),
        .vc_ack       (vc_ack),
        .ors_data_out (ors_data_out),
        .valid_data   (valid_data),
        .grant_vc     (grant_vc),
        .busy         (busy),
        .pkt_count    (pkt_count),
        .len_err      (len_err)
    );

    always #5 wr_clk = ~wr_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Per-VC input FIFOs as the bench sees them; bit DW marks a tail flit.
    logic [DW:0] fifo [NV][256];
    int          wp [NV];
    int          rp [NV];
    bit          hold [NV];
    bit          bp_off;

    // Reference model state: who owns the port and what the output buffer should see.
    bit            m_locked;
    int            m_owner;
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_pkt;
    int            m_flits;
    bit            m_lenerr;
    logic [NV-1:0] exp_ack;
    logic [NV-1:0] cap_ack;

    function automatic int occ(input int v);
        return wp[v] - rp[v];
    endfunction

    function automatic bit drained();
        bit e = 1'b1;
        for (int v = 0; v < NV; v++) if (occ(v) != 0) e = 1'b0;
        return e && !m_locked;
    endfunction

    function automatic logic [DW-1:0] flit_word(input int v, input int f, input int tag);
        return DW'((tag << 16) | (v << 8) | f);
    endfunction

    task automatic push_pkt(input int v, input int len, input int tag);
        for (int f = 0; f < len; f++) begin
            fifo[v][wp[v] % 256] = {(f == len - 1), flit_word(v, f, tag)};
            wp[v]++;
        end
    endtask

    task automatic apply_inputs();
        logic [DW:0] h;
        for (int v = 0; v < NV; v++) begin
            h = fifo[v][rp[v] % 256];
            vc_req[v]          = (occ(v) > 0) && !hold[v];
            vc_data[v*DW +: DW] = h[DW-1:0];
            vc_tail[v]         = h[DW];
        end
        buf_rd  = !bp_off;
        exp_ack = '0;
        if (m_locked && vc_req[m_owner] && buf_rd) exp_ack[m_owner] = 1'b1;
    endtask

    task automatic model_update();
        logic [DW:0] h;
        bit          found;
        int          base;
        if (!m_locked) begin
            m_valid = 1'b0;
            found   = 1'b0;
            base    = m_owner;
            for (int k = 1; k <= NV; k++) begin
                int c = (base + k) % NV;
                if (!found && vc_req[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                end
            end
            if (found) m_locked = 1'b1;
        end else if (exp_ack[m_owner]) begin
            h = fifo[m_owner][rp[m_owner] % 256];
            rp[m_owner]++;
            m_valid = 1'b1;
            m_data  = h[DW-1:0];
            if (h[DW]) begin
                m_locked = 1'b0;
                m_pkt++;
                m_flits = 0;
            end else begin
                if (m_flits < MAXF) m_flits++;
                if (m_flits >= MAXF) m_lenerr = 1'b1;
            end
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = NV - 1;
        m_valid  = 1'b0;
        m_data   = '0;
        m_pkt    = 0;
        m_flits  = 0;
        m_lenerr = 1'b0;
        bp_off   = 1'b0;
        for (int v = 0; v < NV; v++) begin
            rp[v]   = wp[v];
            hold[v] = 1'b0;
        end
    endtask

    // One clock: drive at negedge, capture the combinational ack, step DUT and model together.
    task automatic step();
        @(negedge wr_clk);
        apply_inputs();
        #1;
        cap_ack = vc_ack;
        @(posedge wr_clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        #2;
        reset  = 1'b0;
        vc_req = '0;
        model_reset();
        @(negedge wr_clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int v = 0; v < NV; v++) begin
            wp[v] = 0;
            rp[v] = 0;
        end
        model_reset();
        reset   = 1'b0;
        vc_req  = '1;
        vc_tail = '1;
        buf_rd  = 1'b1;
        for (int v = 0; v < NV; v++) vc_data[v*DW +: DW] = $urandom;
        repeat (3) @(posedge wr_clk);
        #1;
        vectors++; if (vc_ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack: got %b expected 0000", vc_ack); end
        vectors++; if (valid_data !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (grant_vc !== 2'd3) begin miscompares++; $display("FAIL reset_grant: got %0d expected 3", grant_vc); end
        vectors++; if (pkt_count !== 16'd0) begin miscompares++; $display("FAIL reset_pkt: got %0d expected 0", pkt_count); end
        vectors++; if (len_err !== 1'b0) begin miscompares++; $display("FAIL reset_len_err: got %b expected 0", len_err); end
        vectors++; if (ors_data_out !== 32'd0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", ors_data_out); end
        @(negedge wr_clk);
        reset  = 1'b1;
        vc_req = '0;
    endtask

    task automatic test_single_packet();
        logic [DW-1:0] a [3];
        logic [NV-1:0] ea;
        a[0] = 32'hA1A1_0001;
        a[1] = 32'hA2A2_0002;
        a[2] = 32'hA3A3_0003;
        for (int f = 0; f < 3; f++) begin
            fifo[2][wp[2] % 256] = {(f == 2), a[f]};
            wp[2]++;
        end
        for (int c = 1; c <= 6; c++) begin
            step();
            ea = (c >= 2 && c <= 4) ? 4'b0100 : 4'b0000;
            vectors++; if (cap_ack !== ea) begin miscompares++; $display("FAIL single_ack c%0d: got %b expected %b", c, cap_ack, ea); end
            vectors++; if (valid_data !== (c >= 2 && c <= 4)) begin miscompares++; $display("FAIL single_valid c%0d: got %b", c, valid_data); end
            if (c >= 2 && c <= 4) begin
                vectors++; if (ors_data_out !== a[c-2]) begin miscompares++; $display("FAIL single_data c%0d: got %h expected %h", c, ors_data_out, a[c-2]); end
            end
            if (c == 1) begin
                vectors++; if (grant_vc !== 2'd2) begin miscompares++; $display("FAIL single_grant: got %0d expected 2", grant_vc); end
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy); end
            end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: busy got %b expected 0", busy); end
        vectors++; if (pkt_count !== 16'd1) begin miscompares++; $display("FAIL single_pkt: got %0d expected 1", pkt_count); end
    endtask

    task automatic test_round_robin();
        int got [8];
        int exp_order [6];
        int n = 0;
        int cyc = 0;
        bit prev_busy;
        exp_order = '{0, 1, 3, 0, 1, 3};
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_pkt(0, 2, r);
            push_pkt(1, 2, r);
            push_pkt(3, 2, r);
        end
        prev_busy = 1'b0;
        while (!drained() && cyc < 60) begin
            step();
            cyc++;
            vectors++; if (cap_ack !== exp_ack) begin miscompares++; $display("FAIL rr_ack: got %b expected %b", cap_ack, exp_ack); end
            vectors++; if (valid_data !== m_valid) begin miscompares++; $display("FAIL rr_valid: got %b expected %b", valid_data, m_valid); end
            if (m_valid) begin
                vectors++; if (ors_data_out !== m_data) begin miscompares++; $display("FAIL rr_data: got %h expected %h", ors_data_out, m_data); end
            end
            if (busy && !prev_busy && n < 8) begin
                got[n] = grant_vc;
                n++;
            end
            prev_busy = busy;
        end
        vectors++; if (cyc >= 60) begin miscompares++; $display("FAIL rr_timeout: got %0d cycles expected <60", cyc); end
        vectors++; if (n != 6) begin miscompares++; $display("FAIL rr_grants: got %0d grants expected 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            vectors++; if (got[i] != exp_order[i]) begin miscompares++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got[i], exp_order[i]); end
        end
    endtask

    task automatic test_backpressure();
        int nack = 0;
        int nout = 0;
        int bp_left = 0;
        int cyc = 0;
        bit bp_done = 1'b0;
        push_pkt(1, 6, 'h55);
        while (!drained() && cyc < 40) begin
            if (nack == 2 && !bp_done) begin
                bp_off  = 1'b1;
                bp_left = 4;
                bp_done = 1'b1;
            end
            step();
            cyc++;
            if (cap_ack[1]) nack++;
            vectors++; if (cap_ack !== exp_ack) begin miscompares++; $display("FAIL bp_ack: got %b expected %b", cap_ack, exp_ack); end
            if (bp_left > 0) begin
                vectors++; if (cap_ack !== 4'b0000) begin miscompares++; $display("FAIL bp_stall_ack: got %b expected 0000", cap_ack); end
                vectors++; if (valid_data !== 1'b0) begin miscompares++; $display("FAIL bp_stall_valid: got %b expected 0", valid_data); end
                bp_left--;
                if (bp_left == 0) bp_off = 1'b0;
            end
            if (valid_data) begin
                vectors++; if (ors_data_out !== flit_word(1, nout, 'h55)) begin miscompares++; $display("FAIL bp_data[%0d]: got %h expected %h", nout, ors_data_out, flit_word(1, nout, 'h55)); end
                nout++;
            end
        end
        vectors++; if (nout != 6) begin miscompares++; $display("FAIL bp_count: got %0d flits expected 6", nout); end
    endtask

    task automatic test_owner_bubble();
        int nack0 = 0;
        int nout0 = 0;
        int hold_left = 0;
        int cyc = 0;
        bit pushed2 = 1'b0;
        bit held = 1'b0;
        push_pkt(0, 5, 'h0B);
        while (!drained() && cyc < 50) begin
            if (nack0 == 1 && !pushed2) begin
                push_pkt(2, 2, 'h2B);
                pushed2 = 1'b1;
            end
            if (nack0 == 2 && !held) begin
                hold[0]   = 1'b1;
                hold_left = 3;
                held      = 1'b1;
            end
            step();
            cyc++;
            if (cap_ack[0]) nack0++;
            vectors++; if (cap_ack !== exp_ack) begin miscompares++; $display("FAIL bubble_ack: got %b expected %b", cap_ack, exp_ack); end
            if (hold_left > 0) begin
                vectors++; if (cap_ack !== 4'b0000) begin miscompares++; $display("FAIL bubble_hold_ack: got %b expected 0000", cap_ack); end
                vectors++; if (busy !== 1'b1 || grant_vc !== 2'd0) begin miscompares++; $display("FAIL bubble_lock: got busy=%b grant=%0d expected busy=1 grant=0", busy, grant_vc); end
                hold_left--;
                if (hold_left == 0) hold[0] = 1'b0;
            end
            if (nout0 < 5) begin
                vectors++; if (cap_ack[2] !== 1'b0) begin miscompares++; $display("FAIL bubble_vc2_early: got ack %b expected 0", cap_ack[2]); end
            end
            if (valid_data) begin
                vectors++; if (ors_data_out !== m_data) begin miscompares++; $display("FAIL bubble_data: got %h expected %h", ors_data_out, m_data); end
                if (ors_data_out[15:8] == 8'd0) nout0++;
            end
        end
        vectors++; if (nout0 != 5 || grant_vc !== 2'd2) begin miscompares++; $display("FAIL bubble_end: got vc0 flits=%0d grant=%0d expected 5 and 2", nout0, grant_vc); end
    endtask

    task automatic test_len_err();
        int nack = 0;
        int nout = 0;
        int cyc = 0;
        push_pkt(3, MAXF + 1, 'h17);
        while (!drained() && cyc < 60) begin
            step();
            cyc++;
            if (cap_ack[3]) nack++;
            vectors++; if (len_err !== (nack >= MAXF)) begin miscompares++; $display("FAIL len_err after ack %0d: got %b expected %b", nack, len_err, (nack >= MAXF)); end
            if (valid_data) begin
                vectors++; if (ors_data_out !== flit_word(3, nout, 'h17)) begin miscompares++; $display("FAIL len_data[%0d]: got %h expected %h", nout, ors_data_out, flit_word(3, nout, 'h17)); end
                nout++;
            end
        end
        vectors++; if (nout != MAXF + 1) begin miscompares++; $display("FAIL len_count: got %0d flits expected %0d", nout, MAXF + 1); end
        repeat (3) step();
        vectors++; if (len_err !== 1'b1) begin miscompares++; $display("FAIL len_sticky: got %b expected 1", len_err); end
    endtask

    task automatic test_random();
        int tag = 'h100;
        int cyc = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) begin
                int v = $urandom_range(NV - 1);
                if (occ(v) < 40) begin
                    push_pkt(v, $urandom_range(6, 1), tag);
                    tag++;
                end
            end
            bp_off = ($urandom_range(4) == 0);
            for (int v = 0; v < NV; v++) hold[v] = ($urandom_range(9) == 0);
            step();
            vectors++;
            if (cap_ack !== exp_ack || valid_data !== m_valid || busy !== m_locked
                || grant_vc !== 2'(m_owner) || pkt_count !== 16'(m_pkt) || len_err !== m_lenerr
                || (m_valid && ors_data_out !== m_data)) begin
                miscompares++;
                $display("FAIL rand cycle %0d: got ack=%b v=%b d=%h busy=%b g=%0d pkt=%0d le=%b expected ack=%b v=%b d=%h busy=%b g=%0d pkt=%0d le=%b",
                         i, cap_ack, valid_data, ors_data_out, busy, grant_vc, pkt_count, len_err,
                         exp_ack, m_valid, m_data, m_locked, m_owner, m_pkt, m_lenerr);
            end
        end
        bp_off = 1'b0;
        for (int v = 0; v < NV; v++) hold[v] = 1'b0;
        while (!drained() && cyc < 400) begin
            step();
            cyc++;
            vectors++;
            if (cap_ack !== exp_ack || valid_data !== m_valid || (m_valid && ors_data_out !== m_data)) begin
                miscompares++;
                $display("FAIL rand_drain: got ack=%b v=%b d=%h expected ack=%b v=%b d=%h",
                         cap_ack, valid_data, ors_data_out, exp_ack, m_valid, m_data);
            end
        end
        vectors++; if (pkt_count !== 16'(m_pkt)) begin miscompares++; $display("FAIL rand_pkt: got %0d expected %0d", pkt_count, m_pkt); end
    endtask

    task automatic test_async_reset();
        int nack = 0;
        int cyc = 0;
        do_reset();
        push_pkt(1, 8, 'hAA);
        while (nack < 3 && cyc < 20) begin
            step();
            cyc++;
            if (cap_ack[1]) nack++;
        end
        vectors++; if (valid_data !== 1'b1) begin miscompares++; $display("FAIL areset_pre_valid: got %b expected 1", valid_data); end
        @(negedge wr_clk);
        #3;
        reset = 1'b0;
        #1;
        vectors++; if (valid_data !== 1'b0) begin miscompares++; $display("FAIL areset_valid: got %b expected 0", valid_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b expected 0", busy); end
        vectors++; if (grant_vc !== 2'd3) begin miscompares++; $display("FAIL areset_grant: got %0d expected 3", grant_vc); end
        vectors++; if (vc_ack !== 4'b0000) begin miscompares++; $display("FAIL areset_ack: got %b expected 0000", vc_ack); end
        model_reset();
        @(negedge wr_clk);
        reset  = 1'b1;
        vc_req = '0;
        for (int v = 0; v < NV; v++) push_pkt(v, 1, 'hC0);
        step();
        vectors++; if (grant_vc !== 2'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL areset_rearb: got grant=%0d busy=%b expected 0 and 1", grant_vc, busy); end
        cyc = 0;
        while (!drained() && cyc < 30) begin
            step();
            cyc++;
            vectors++; if (valid_data !== m_valid || (m_valid && ors_data_out !== m_data)) begin miscompares++; $display("FAIL areset_drain: got v=%b d=%h expected v=%b d=%h", valid_data, ors_data_out, m_valid, m_data); end
        end
        vectors++; if (pkt_count !== 16'd4) begin miscompares++; $display("FAIL areset_pkt: got %0d expected 4", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_owner_bubble();
        test_len_err();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/output_vc_scheduler.md
Name: output_vc_scheduler

Overview:
- Wormhole-style scheduler that shares one router output port between NUM_VC virtual-channel input queues.
- Picks a VC by round-robin and locks the port to it from head flit to tail flit.
- Pops flits from the owning VC only while the output buffer reports space, and drives that buffer's write side (ors_data_out / valid_data).
- Sits between the per-VC input FIFOs and the output_buffer instance of each router port.

Parameters:
- NUM_VC, 4: number of virtual channels competing for the port.
- VC_W, 2: width of the VC index; must equal clog2(NUM_VC).
- DATA_W, 32: flit width.
- MAX_FLITS, 16: longest legal packet, in flits including head and tail.
- CNT_W, 16: width of the delivered-packet counter.

Ports:
- wr_clk, input, 1: single clock; the output buffer write clock.
- reset, input, 1: asynchronous, active-low reset (asserted at 0).
- vc_req, input, NUM_VC: per-VC "flit available" (input FIFO not empty).
- vc_data, input, NUM_VC*DATA_W: flattened flit heads; VC i occupies bits [i*DATA_W +: DATA_W].
- vc_tail, input, NUM_VC: the presented flit of VC i is the last flit of its packet.
- buf_rd, input, 1: output buffer has space (the buffer's rd = !output_full).
- vc_ack, output, NUM_VC: combinational one-hot pop strobe to the owning VC FIFO.
- ors_data_out, output, DATA_W: registered flit to the output buffer.
- valid_data, output, 1: registered write strobe for ors_data_out.
- grant_vc, output, VC_W: current or last owner index.
- busy, output, 1: port is locked to a VC.
- pkt_count, output, CNT_W: packets delivered, i.e. tails written.
- len_err, output, 1: sticky flag; a packet exceeded MAX_FLITS.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, ors_data_out=0, valid_data=0, grant_vc=NUM_VC-1, busy=0, pkt_count=0, len_err=0, flit counter=0.
  - vc_ack=0 while reset is asserted.
  - Reset asserted mid-packet abandons the packet. No partial-packet recovery.
- FSM states: IDLE and LOCK.
- IDLE:
  - If any vc_req is set, choose the winner as the first requester scanning from (grant_vc+1) mod NUM_VC upward with wrap-around.
  - Register the winner into grant_vc, set busy=1, go to LOCK.
  - No flit is transferred in the arbitration cycle. buf_rd is ignored in IDLE.
- LOCK:
  - vc_ack[grant_vc] = vc_req[grant_vc] & buf_rd. All other ack bits are 0.
  - On an ack edge: ors_data_out <= vc_data[grant_vc], valid_data <= 1, flit counter increments.
  - Otherwise valid_data <= 0 and ors_data_out holds its value.
  - Latency: flit accepted in cycle n appears on ors_data_out/valid_data in cycle n+1.
- Tail handling:
  - An ack with vc_tail[grant_vc]=1 returns the FSM to IDLE, sets busy=0, increments pkt_count (wraps at 2^CNT_W) and clears the flit counter.
  - grant_vc keeps the last owner, which is the round-robin pointer.
  - Minimum packet-to-packet spacing on the port: 1 idle arbitration cycle.
- Owner bubble: if vc_req[owner] drops mid-packet, the port stays locked (wormhole). Other VCs are not served until the tail is sent.
- Full back-pressure:
  - buf_rd=0 suppresses the ack in that same cycle.
  - Because valid_data is registered, the output buffer must drop buf_rd with at least 1 free entry remaining. That buffer provides this headroom by design.
- Length check: when the flit counter reaches MAX_FLITS without a tail, set len_err=1.
  - len_err stays set until reset.
  - Transfer continues and the counter saturates.
- Simultaneous events:
  - A tail ack and new requests in the same cycle: the new requests are arbitrated next cycle (in IDLE).
  - A single-flit packet (head = tail) takes 1 LOCK cycle.

Decomposition:
- Shared package holds NUM_VC, VC_W, DATA_W, MAX_FLITS and the state encoding (IDLE=1'b0, LOCK=1'b1).
- One natural sub-module, rr_arbiter: inputs req[NUM_VC] and last[VC_W]; outputs gnt_idx and any_req. Purely combinational rotate-priority encoder.
- The FSM, datapath and counters stay in output_vc_scheduler.

Test Plan:
- Reset, then VC2 alone sends a 3-flit packet (A1, A2, A3 with tail) with buf_rd=1.
  - Expect: grant_vc=2 in cycle 1; vc_ack[2] in cycles 2-4; valid_data in cycles 3-5 with data A1..A3; then busy=0 and pkt_count=1.
- VC0, VC1 and VC3 all request continuously with 2-flit packets.
  - Expect grant order 0, 1, 3, 0, and no interleaving of flits between packets.
- Mid-packet on VC1, force buf_rd=0 for 4 cycles.
  - Expect vc_ack=0 for those cycles, valid_data=0 one cycle later, and no flit lost or duplicated on resume.
- VC0 drops vc_req for 3 cycles mid-packet while VC2 requests.
  - Expect the port to stay locked to VC0 and VC2 to receive no ack until VC0's tail is written.
- Send a packet of MAX_FLITS+1 flits on VC3.
  - Expect len_err=1 after the 16th ack, all 17 flits delivered, and len_err to survive until reset.
- Drive reset=0 asynchronously mid-packet.
  - Expect immediate valid_data=0, busy=0 and grant_vc=3. Next arbitration with all VCs requesting grants VC0.
